// File: rtl/ser_pkg.sv
// Shared constants and types for the round-robin serializer scheduler.
// The serializer takes 16-bit words and emits 2-bit symbols, MSB pair first.
package ser_pkg;

  localparam int SER_WORD_W = 16;
  localparam int SER_SYM_W  = 2;
  localparam int SER_SYMS   = SER_WORD_W / SER_SYM_W;
  localparam int SLOT_CNT_W = 4;

  localparam logic [SLOT_CNT_W-1:0] SLOT_CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

endpackage

// File: rtl/ser_rr_arb.sv
// Combinational rotating-priority arbiter.
// The search starts one past last_grant and wraps modulo NUM_REQ.
module ser_rr_arb
  import ser_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  int idx;

  // Walk from the farthest offset down to the nearest, so the nearest valid source wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (enable && req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_rr_scheduler.sv
// Round-robin scheduler sharing one 16-bit-in / 2-bit-out serializer among NUM_REQ sources.
// Grants a source, strobes the word into the serializer, tracks symbol ownership and desync.
module ser_rr_scheduler
  import ser_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*SER_WORD_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           ser_load_en,
  output logic [SER_WORD_W-1:0]          ser_p_in,
  input  logic                           ser_data_valid,
  output logic                           owner_valid,
  output logic [ID_W-1:0]                owner_id,
  output logic                           word_done,
  output logic                           err_desync,
  input  logic                           err_clear
);

  localparam logic [SLOT_CNT_W-1:0] SLOT_THR  = SLOT_CNT_W'(SER_SYMS - 1 + GAP_CYCLES);
  localparam int                    SYM_CNT_W = $clog2(SER_SYMS);
  localparam logic [SYM_CNT_W-1:0]  LAST_SYM  = SYM_CNT_W'(SER_SYMS - 1);

  sched_state_e state_q, state_d;

  logic [SLOT_CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic                  load_q, load_d;
  logic [SER_WORD_W-1:0] p_in_q, p_in_d;
  logic                  own_valid_q, own_valid_d;
  logic [ID_W-1:0]       own_id_q, own_id_d;
  logic [SYM_CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic                  err_q, err_d;

  logic                  slot_open;
  logic                  any_grant;
  logic [ID_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]    grant;

  ser_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (slot_open),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_grant) state_d = BUSY;
      BUSY:    if (!any_grant && slot_cnt_q >= SLOT_THR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst_n gates the grant so req_ready is low for the whole reset interval.
  always_comb begin
    slot_open = rst_n && enable && (state_q == IDLE || slot_cnt_q >= SLOT_THR);
  end

  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= SLOT_CNT_MAX;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      load_q       <= 1'b0;
      p_in_q       <= '0;
      own_valid_q  <= 1'b0;
      own_id_q     <= '0;
      sym_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      last_grant_q <= last_grant_d;
      load_q       <= load_d;
      p_in_q       <= p_in_d;
      own_valid_q  <= own_valid_d;
      own_id_q     <= own_id_d;
      sym_cnt_q    <= sym_cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    last_grant_d = last_grant_q;
    p_in_d       = p_in_q;
    load_d       = any_grant;
    if (any_grant) begin
      slot_cnt_d   = '0;
      last_grant_d = grant_idx;
      p_in_d       = req_data[int'(grant_idx)*SER_WORD_W +: SER_WORD_W];
    end else if (slot_cnt_q != SLOT_CNT_MAX) begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end

    // A load in the last symbol cycle restarts the window without a gap.
    own_valid_d = own_valid_q;
    own_id_d    = own_id_q;
    sym_cnt_d   = sym_cnt_q;
    if (load_q) begin
      own_valid_d = 1'b1;
      own_id_d    = last_grant_q;
      sym_cnt_d   = '0;
    end else if (own_valid_q) begin
      if (sym_cnt_q == LAST_SYM) own_valid_d = 1'b0;
      else                       sym_cnt_d   = sym_cnt_q + 1'b1;
    end

    if (ser_data_valid != own_valid_q) err_d = 1'b1;
    else if (err_clear)                err_d = 1'b0;
    else                               err_d = err_q;
  end

  assign ser_load_en = load_q;
  assign ser_p_in    = p_in_q;
  assign owner_valid = own_valid_q;
  assign owner_id    = own_id_q;
  assign word_done   = own_valid_q && (sym_cnt_q == LAST_SYM);
  assign err_desync  = err_q;

endmodule

// File: tb/tb_ser_rr_scheduler.sv
// Bench for ser_rr_scheduler: two instances (gap 0 and gap 3) checked every cycle
// against a slot/time reference model, plus directed spot checks.
module tb_ser_rr_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   rv  [2];
  logic [N*16-1:0] rd [2];
  logic           en  [2];
  logic           clr [2];
  logic           sdv [2];
  logic [N-1:0]   rdy [2];
  logic           ld  [2];
  logic [15:0]    pin [2];
  logic           ov  [2];
  logic [1:0]     oid [2];
  logic           wd  [2];
  logic           err [2];

  ser_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .req_valid(rv[0]), .req_data(rd[0]),
    .req_ready(rdy[0]), .ser_load_en(ld[0]), .ser_p_in(pin[0]), .ser_data_valid(sdv[0]),
    .owner_valid(ov[0]), .owner_id(oid[0]), .word_done(wd[0]), .err_desync(err[0]),
    .err_clear(clr[0]));

  ser_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .req_valid(rv[1]), .req_data(rd[1]),
    .req_ready(rdy[1]), .ser_load_en(ld[1]), .ser_p_in(pin[1]), .ser_data_valid(sdv[1]),
    .owner_valid(ov[1]), .owner_id(oid[1]), .word_done(wd[1]), .err_desync(err[1]),
    .err_clear(clr[1]));

  int n_checks;
  int n_err;

  // Staged inputs for the next cycle
  logic [N-1:0]    s_rv  [2];
  logic [N*16-1:0] s_rd  [2];
  logic            s_en  [2];
  logic            s_clr [2];
  logic            s_inj [2];

  // Reference model: absolute cycle time, earliest next slot, ring of scheduled events
  int          t [2];
  int          next_slot [2];
  int          last [2];
  logic        err_m [2];
  logic [15:0] pin_m [2];
  logic        m_ov  [2][64];
  logic        m_ld  [2][64];
  logic        m_wd  [2][64];
  int          m_id  [2][64];
  logic [15:0] m_ldd [2][64];

  function automatic int gap(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; next_slot[k] = 0; last[k] = N - 1; err_m[k] = 1'b0; pin_m[k] = '0;
      for (int j = 0; j < 64; j++) begin
        m_ov[k][j] = 1'b0; m_ld[k][j] = 1'b0; m_wd[k][j] = 1'b0; m_id[k][j] = 0; m_ldd[k][j] = '0;
      end
    end
  endtask

  task automatic model_check(input int k);
    int s, w, c;
    logic [N-1:0] rexp;
    s = t[k] % 64;
    rexp = '0;
    w = -1;
    if (en[k] && t[k] >= next_slot[k]) begin
      for (int i = 1; i <= N; i++) begin
        c = (last[k] + i) % N;
        if (w < 0 && rv[k][c]) w = c;
      end
      if (w >= 0) begin
        rexp[w] = 1'b1;
        last[k] = w;
        next_slot[k] = t[k] + 8 + gap(k);
        m_ld[k][(s + 1) % 64] = 1'b1;
        m_ldd[k][(s + 1) % 64] = rd[k][16*w +: 16];
        for (int j = 2; j <= 9; j++) begin
          m_ov[k][(s + j) % 64] = 1'b1;
          m_id[k][(s + j) % 64] = w;
        end
        m_wd[k][(s + 9) % 64] = 1'b1;
      end
    end
    if (m_ld[k][s]) pin_m[k] = m_ldd[k][s];
    chk($sformatf("req_ready[%0d] t=%0d", k, t[k]), 32'(rdy[k]), 32'(rexp));
    chk($sformatf("ser_load_en[%0d] t=%0d", k, t[k]), 32'(ld[k]), 32'(m_ld[k][s]));
    chk($sformatf("ser_p_in[%0d] t=%0d", k, t[k]), 32'(pin[k]), 32'(pin_m[k]));
    chk($sformatf("owner_valid[%0d] t=%0d", k, t[k]), 32'(ov[k]), 32'(m_ov[k][s]));
    if (m_ov[k][s]) chk($sformatf("owner_id[%0d] t=%0d", k, t[k]), 32'(oid[k]), 32'(m_id[k][s]));
    chk($sformatf("word_done[%0d] t=%0d", k, t[k]), 32'(wd[k]), 32'(m_wd[k][s]));
    chk($sformatf("err_desync[%0d] t=%0d", k, t[k]), 32'(err[k]), 32'(err_m[k]));
    err_m[k] = (sdv[k] !== m_ov[k][s]) || (err_m[k] && !clr[k]);
    m_ov[k][s] = 1'b0; m_ld[k][s] = 1'b0; m_wd[k][s] = 1'b0;
    t[k]++;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rv[k]  = s_rv[k];
      rd[k]  = s_rd[k];
      en[k]  = s_en[k];
      clr[k] = s_clr[k];
      sdv[k] = m_ov[k][t[k] % 64] ^ s_inj[k];
    end
    #1;
    model_check(0);
    model_check(1);
    for (int k = 0; k < 2; k++) begin
      s_clr[k] = 1'b0;
      s_inj[k] = 1'b0;
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, " req_ready"}, 32'(rdy[k]), 32'd0);
    chk({tag, " ser_load_en"}, 32'(ld[k]), 32'd0);
    chk({tag, " ser_p_in"}, 32'(pin[k]), 32'd0);
    chk({tag, " owner_valid"}, 32'(ov[k]), 32'd0);
    chk({tag, " owner_id"}, 32'(oid[k]), 32'd0);
    chk({tag, " word_done"}, 32'(wd[k]), 32'd0);
    chk({tag, " err_desync"}, 32'(err[k]), 32'd0);
  endtask

  initial begin
    int q[$];
    n_checks = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_rv[k] = '0; s_rd[k] = '0; s_en[k] = 1'b1; s_clr[k] = 1'b0; s_inj[k] = 1'b0;
      rv[k] = '0; rd[k] = '0; en[k] = 1'b0; clr[k] = 1'b0; sdv[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");

    // Single word from source 1
    s_rv[0] = 4'b0010;
    s_rd[0] = {$urandom, $urandom};
    s_rd[0][31:16] = 16'hB4E1;
    run_cycle();
    chk("sw ready", 32'(rdy[0]), 32'b0010);
    s_rv[0] = '0;
    run_cycle();
    chk("sw load", 32'(ld[0]), 32'd1);
    chk("sw p_in", 32'(pin[0]), 32'hB4E1);
    repeat (7) run_cycle();
    run_cycle();
    chk("sw word_done", 32'(wd[0]), 32'd1);
    chk("sw owner_id", 32'(oid[0]), 32'd1);
    chk("sw err", 32'(err[0]), 32'd0);
    repeat (4) run_cycle();

    // All sources valid on gap-0, source 2 alone on gap-3
    s_rv[0] = 4'hF;
    s_rv[1] = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      s_rd[0] = {$urandom, $urandom};
      s_rd[1] = {$urandom, $urandom};
      run_cycle();
      if (c == 0) chk("rr first grant", 32'(rdy[0]), 32'b0100);
      if (ld[1]) q.push_back(c);
    end
    chk("gap load count", 32'(q.size() >= 3), 32'd1);
    if (q.size() >= 3) begin
      chk("gap first load", 32'(q[0]), 32'd1);
      chk("gap spacing 1", 32'(q[1] - q[0]), 32'd11);
      chk("gap spacing 2", 32'(q[2] - q[1]), 32'd11);
    end
    s_rv[0] = '0;
    s_rv[1] = '0;
    repeat (12) run_cycle();

    // enable dropped mid-word
    s_rv[0] = 4'hF;
    for (int c = 0; c < 16; c++) begin
      s_en[0] = (c < 4 || c == 15);
      run_cycle();
      if (c >= 4 && c <= 14) chk($sformatf("en low ready c=%0d", c), 32'(rdy[0]), 32'd0);
      if (c == 9) chk("en low word_done", 32'(wd[0]), 32'd1);
      if (c == 15) chk("en resume", 32'(rdy[0] != '0), 32'd1);
    end
    s_rv[0] = '0;
    s_en[0] = 1'b1;
    repeat (12) run_cycle();

    // Desync detection, clear, and set-beats-clear
    for (int c = 0; c < 14; c++) begin
      if (c == 5 || c == 10) s_inj[0] = 1'b1;
      if (c == 8 || c == 10 || c == 12) s_clr[0] = 1'b1;
      run_cycle();
      if (c == 6 || c == 7) chk($sformatf("err set c=%0d", c), 32'(err[0]), 32'd1);
      if (c == 9) chk("err cleared", 32'(err[0]), 32'd0);
      if (c == 11) chk("err set wins", 32'(err[0]), 32'd1);
      if (c == 13) chk("err cleared again", 32'(err[0]), 32'd0);
    end

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        s_rv[k]  = N'($urandom_range(0, 15));
        s_rd[k]  = {$urandom, $urandom};
        s_en[k]  = ($urandom_range(0, 9) != 0);
        s_clr[k] = ($urandom_range(0, 19) == 0);
        s_inj[k] = ($urandom_range(0, 49) == 0);
      end
      run_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      s_rv[k] = '0; s_en[k] = 1'b1; s_clr[k] = 1'b1;
    end
    repeat (12) run_cycle();

    // Reset in the middle of a word
    s_rv[0] = 4'b0100;
    s_rd[0] = {$urandom, $urandom};
    run_cycle();
    s_rv[0] = '0;
    repeat (4) run_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    rv[0] = 4'hF;
    rv[1] = 4'hF;
    #1;
    chk_zero(0, "midreset0");
    chk_zero(1, "midreset1");
    repeat (2) @(negedge clk);
    model_reset();
    s_rv[0] = 4'hF;
    s_rv[1] = 4'hF;
    run_cycle();
    chk("post reset first grant", 32'(rdy[0]), 32'b0001);
    repeat (20) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
